// File: rtl/fft_peak_pitch_tracker.sv
// Band-limited peak finder over one frame of FFT magnitude bins; emits the winning bin index per frame.
// Optional 3-tap median smoothing of the per-frame result is enabled by defining PITCH_MEDIAN_SMOOTH_EN.
module fft_peak_pitch_tracker #(
    parameter int NSAMPLES = 1024,
    parameter int MAG_W    = 32,
    parameter int MIN_BIN  = 2,
    parameter int MAX_BIN  = 511
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [MAG_W-1:0]            threshold,
    input  logic [MAG_W-1:0]            mag_input_data,
    input  logic                        mag_input_valid,
    output logic                        mag_input_ready,
    output logic [$clog2(NSAMPLES)-1:0] pitch_output_data,
    output logic                        pitch_output_valid,
    input  logic                        pitch_output_ready,
    output logic                        frame_overflow
);

    localparam int IW = $clog2(NSAMPLES);
    localparam int SW = $clog2(2 * NSAMPLES + 1);
    localparam logic [IW-1:0] MIN_IDX   = IW'(MIN_BIN);
    localparam logic [IW-1:0] MAX_IDX   = IW'(MAX_BIN);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NSAMPLES - 1);
    localparam logic [SW-1:0] STALL_LIM = SW'(2 * NSAMPLES);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_t;

    state_t             state_r;
    logic [IW-1:0]      bin_cnt_r;
    logic [MAG_W-1:0]   max_r;
    logic [IW-1:0]      idx_r;
    logic [SW-1:0]      stall_cnt_r;

    logic               accept_s;
    logic               in_band_s;
    logic               take_s;
    logic [MAG_W-1:0]   final_max_s;
    logic [IW-1:0]      final_idx_s;
    logic [IW-1:0]      raw_s;
    logic [IW-1:0]      out_s;

`ifdef PITCH_MEDIAN_SMOOTH_EN
    logic [IW-1:0]      h0_r;
    logic [IW-1:0]      h1_r;
    logic [IW-1:0]      h2_r;

    function automatic logic [IW-1:0] median3(input logic [IW-1:0] a,
                                              input logic [IW-1:0] b,
                                              input logic [IW-1:0] c);
        logic [IW-1:0] lo;
        logic [IW-1:0] hi;
        logic [IW-1:0] mid;
        lo  = (a < b) ? a : b;
        hi  = (a < b) ? b : a;
        mid = (hi < c) ? hi : c;
        return (lo > mid) ? lo : mid;
    endfunction
`endif

    // Peak tracking and end-of-frame result, including the final bin if it wins
    always_comb begin
        accept_s    = mag_input_valid && mag_input_ready;
        in_band_s   = (bin_cnt_r >= MIN_IDX) && (bin_cnt_r <= MAX_IDX);
        take_s      = accept_s && in_band_s && (mag_input_data > max_r);
        final_max_s = take_s ? mag_input_data : max_r;
        final_idx_s = take_s ? bin_cnt_r : idx_r;
        if ((final_max_s >= threshold) && (final_max_s != {MAG_W{1'b0}})) begin
            raw_s = final_idx_s;
        end else begin
            raw_s = {IW{1'b0}};
        end
`ifdef PITCH_MEDIAN_SMOOTH_EN
        out_s = median3(raw_s, h0_r, h1_r);
`else
        out_s = raw_s;
`endif
    end

    // Frame collection / result hand-off state machine with registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r            <= COLLECT;
            bin_cnt_r          <= {IW{1'b0}};
            max_r              <= {MAG_W{1'b0}};
            idx_r              <= {IW{1'b0}};
            stall_cnt_r        <= {SW{1'b0}};
            mag_input_ready    <= 1'b0;
            pitch_output_valid <= 1'b0;
            pitch_output_data  <= {IW{1'b0}};
            frame_overflow     <= 1'b0;
`ifdef PITCH_MEDIAN_SMOOTH_EN
            h0_r               <= {IW{1'b0}};
            h1_r               <= {IW{1'b0}};
            h2_r               <= {IW{1'b0}};
`endif
        end else begin
            frame_overflow <= 1'b0;
            stall_cnt_r    <= {SW{1'b0}};
            case (state_r)
                COLLECT: begin
                    mag_input_ready <= 1'b1;
                    if (accept_s) begin
                        if (take_s) begin
                            max_r <= mag_input_data;
                            idx_r <= bin_cnt_r;
                        end
                        if (bin_cnt_r == LAST_IDX) begin
                            bin_cnt_r          <= {IW{1'b0}};
                            state_r            <= OUTPUT;
                            mag_input_ready    <= 1'b0;
                            pitch_output_valid <= 1'b1;
                            pitch_output_data  <= out_s;
`ifdef PITCH_MEDIAN_SMOOTH_EN
                            h0_r               <= raw_s;
                            h1_r               <= h0_r;
                            h2_r               <= h1_r;
`endif
                        end else begin
                            bin_cnt_r <= bin_cnt_r + IW'(1);
                        end
                    end
                end
                OUTPUT: begin
                    mag_input_ready <= 1'b0;
                    // Count consecutive stalled-producer cycles; pulse and re-arm past 2*NSAMPLES
                    if (mag_input_valid) begin
                        if (stall_cnt_r == STALL_LIM) begin
                            frame_overflow <= 1'b1;
                            stall_cnt_r    <= {SW{1'b0}};
                        end else begin
                            stall_cnt_r <= stall_cnt_r + SW'(1);
                        end
                    end
                    if (pitch_output_valid && pitch_output_ready) begin
                        pitch_output_valid <= 1'b0;
                        max_r              <= {MAG_W{1'b0}};
                        idx_r              <= {IW{1'b0}};
                        state_r            <= COLLECT;
                    end
                end
                default: begin
                    state_r <= COLLECT;
                end
            endcase
        end
    end

`ifdef PITCH_MEDIAN_SMOOTH_EN
    logic unused_h2_s;
    assign unused_h2_s = ^h2_r;
`endif

endmodule

// File: tb/tb_fft_peak_pitch_tracker.sv
// Directed self-checking bench for fft_peak_pitch_tracker with a 64-bin frame, band 2..31.
// Expected pitches are hand-derived; a small history model covers the optional median smoothing build.
module tb_fft_peak_pitch_tracker;

    localparam int N  = 64;
    localparam int MW = 32;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [MW-1:0] threshold = 32'd100;
    logic [MW-1:0] mag_input_data = 32'd0;
    logic          mag_input_valid = 1'b0;
    logic          mag_input_ready;
    logic [IW-1:0] pitch_output_data;
    logic          pitch_output_valid;
    logic          pitch_output_ready = 1'b0;
    logic          frame_overflow;

    int total = 0;
    int bad   = 0;
    logic [MW-1:0] frame_mag [N];
    logic [IW-1:0] mh0, mh1, mh2;

    fft_peak_pitch_tracker #(
        .NSAMPLES(N), .MAG_W(MW), .MIN_BIN(2), .MAX_BIN(31)
    ) dut (
        .clk(clk), .reset(reset), .threshold(threshold),
        .mag_input_data(mag_input_data), .mag_input_valid(mag_input_valid),
        .mag_input_ready(mag_input_ready),
        .pitch_output_data(pitch_output_data), .pitch_output_valid(pitch_output_valid),
        .pitch_output_ready(pitch_output_ready), .frame_overflow(frame_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [MW-1:0] base);
        for (int i = 0; i < N; i++) frame_mag[i] = base;
    endtask

    // Reference output: raw pitch, or median of the last three raw pitches when smoothing is on
    task automatic model_out(input logic [IW-1:0] raw, output logic [IW-1:0] exp);
`ifdef PITCH_MEDIAN_SMOOTH_EN
        logic [IW-1:0] s [3];
        logic [IW-1:0] t;
        mh2 = mh1; mh1 = mh0; mh0 = raw;
        s[0] = mh0; s[1] = mh1; s[2] = mh2;
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2 - a; b++)
                if (s[b] > s[b+1]) begin t = s[b]; s[b] = s[b+1]; s[b+1] = t; end
        exp = s[1];
`else
        exp = raw;
`endif
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mag_input_valid = 1'b0;
        pitch_output_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("rst_in_ready", mag_input_ready, 0);
        check_eq("rst_valid", pitch_output_valid, 0);
        check_eq("rst_data", pitch_output_data, 0);
        check_eq("rst_ovf", frame_overflow, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_rel_ready", mag_input_ready, 1);
        mh0 = '0; mh1 = '0; mh2 = '0;
    endtask

    // Push bins 0..count-1 of frame_mag, waiting (bounded) for ready before each
    task automatic send_frame(input int count);
        int w;
        for (int i = 0; i < count; i++) begin
            mag_input_data  = frame_mag[i];
            mag_input_valid = 1'b1;
            w = 0;
            while (!mag_input_ready && w < 200) begin
                @(posedge clk); #1;
                w++;
            end
            if (w >= 200) begin
                check_eq("in_ready_timeout", 0, 1);
                mag_input_valid = 1'b0;
                return;
            end
            if (i == N - 1) check_eq("valid_before_last", pitch_output_valid, 0);
            @(posedge clk); #1;
        end
        mag_input_valid = 1'b0;
    endtask

    task automatic take_pitch(input string tag, input logic [IW-1:0] exp);
        check_eq({tag, "_latency"}, pitch_output_valid, 1);
        check_eq(tag, pitch_output_data, exp);
        pitch_output_ready = 1'b1;
        @(posedge clk); #1;
        pitch_output_ready = 1'b0;
        check_eq({tag, "_drop"}, pitch_output_valid, 0);
        check_eq({tag, "_bubble"}, mag_input_ready, 0);
    endtask

    task automatic run_frame(input string tag, input logic [IW-1:0] raw);
        logic [IW-1:0] e;
        send_frame(N);
        model_out(raw, e);
        take_pitch(tag, e);
    endtask

    logic [IW-1:0] e;
    logic [IW-1:0] smooth_exp [4];
    int pulses, first_pulse, unstable, rdy_high;

    initial begin
        do_reset();

        fill(32'd10); frame_mag[10] = 32'd5000;
        run_frame("single_peak", 6'd10);

        fill(32'd10); frame_mag[1] = 32'd9999; frame_mag[40] = 32'd9999; frame_mag[20] = 32'd300;
        run_frame("band_limits", 6'd20);

        fill(32'd10); frame_mag[12] = 32'd7000; frame_mag[25] = 32'd7000;
        run_frame("tie_low", 6'd12);

        fill(32'd10); frame_mag[7] = 32'd99;
        run_frame("thr_below", 6'd0);

        fill(32'd10); frame_mag[7] = 32'd100;
        run_frame("thr_equal", 6'd7);

        fill(32'd10); frame_mag[31] = 32'd800;
        run_frame("last_band_bin", 6'd31);

        // Stalled consumer with the producer still offering data
        fill(32'd10); frame_mag[15] = 32'd4000;
        send_frame(N);
        model_out(6'd15, e);
        mag_input_valid = 1'b1;
        pulses = 0; first_pulse = -1; unstable = 0; rdy_high = 0;
        for (int k = 0; k < 150; k++) begin
            @(posedge clk); #1;
            if (pitch_output_data !== e || pitch_output_valid !== 1'b1) unstable++;
            if (mag_input_ready) rdy_high++;
            if (frame_overflow) begin
                pulses++;
                if (first_pulse < 0) first_pulse = k + 1;
            end
        end
        mag_input_valid = 1'b0;
        check_eq("bp_stable", unstable, 0);
        check_eq("bp_in_ready_low", rdy_high, 0);
        check_eq("bp_ovf_count", pulses, 1);
        check_eq("bp_ovf_cycle", first_pulse, 129);
        take_pitch("bp_pitch", e);

        fill(32'd10); frame_mag[3] = 32'd2222;
        run_frame("after_bp", 6'd3);

        // Abort a frame mid-way; its peak must never appear
        fill(32'd10); frame_mag[5] = 32'd5000;
        send_frame(30);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check_eq("midrst_valid", pitch_output_valid, 0);
        check_eq("midrst_ready", mag_input_ready, 0);
        @(posedge clk); #1;
        mh0 = '0; mh1 = '0; mh2 = '0;
        fill(32'd10); frame_mag[17] = 32'd5000;
        run_frame("midrst_pitch", 6'd17);

        do_reset();
`ifdef PITCH_MEDIAN_SMOOTH_EN
        smooth_exp[0] = 6'd0;  smooth_exp[1] = 6'd20; smooth_exp[2] = 6'd20; smooth_exp[3] = 6'd20;
`else
        smooth_exp[0] = 6'd20; smooth_exp[1] = 6'd20; smooth_exp[2] = 6'd45 - 6'd20; smooth_exp[3] = 6'd20;
`endif
        for (int f = 0; f < 4; f++) begin
            fill(32'd10);
            frame_mag[(f == 2) ? 25 : 20] = 32'd5000;
            send_frame(N);
            take_pitch($sformatf("smooth_%0d", f), smooth_exp[f]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule
